sdram_readback: RTL and testbench
=================================

// Module: sdram_readback
// PURPOSE
//  Downstream consumer of the capture-fill writer. Once a capture is stored, it reads an inclusive
//  range of 256-bit SDRAM lines through the Avalon-MM read port (burstcount 1, pipelined).
//  Each line is buffered in an internal credit-limited FIFO and serialized into 32-bit words on a
//  valid/ready stream toward the host export path.
//  Lives entirely in the SDRAM clock domain; control inputs arrive already synchronous to sdram_clk.
// PARAMETERS
//  ADDR_W      27   SDRAM line address width
//  DATA_W      256  SDRAM data width; must be a multiple of OUT_W
//  OUT_W       32   output stream word width
//  FIFO_DEPTH  8    line FIFO entries, power of 2, >=2; also max outstanding reads
// PORTS
//  sdram_clk            in   1       sole clock
//  rst_sdram_n          in   1       async assert, active-low reset
//  read_launch          in   1       1-cycle pulse: start a transfer (ignored unless idle)
//  read_abort           in   1       1-cycle pulse: cancel the transfer in progress
//  read_addr_start      in   ADDR_W  first line address, sampled on launch
//  read_addr_end        in   ADDR_W  last line address (inclusive), sampled on launch
//  read_busy            out  1       high from the cycle after launch until return to IDLE
//  sdram_address        out  ADDR_W  Avalon read address
//  sdram_burstcount     out  8       constant 1
//  sdram_read           out  1       Avalon read request
//  sdram_waitrequest    in   1       slave stall
//  sdram_readdata       in   DATA_W  returned line
//  sdram_readdatavalid  in   1       returned line valid
//  out_data             out  OUT_W   stream word
//  out_valid            out  1       stream valid
//  out_ready            in   1       stream ready
//  out_last             out  1       marks the final word of a completed transfer
// BEHAVIOUR
//  Reset: state=IDLE; sdram_read=0; sdram_address=0; read_busy=0; out_valid=0; out_last=0;
//   out_data=0; FIFO empty; outstanding=0. sdram_burstcount is tied to 1.
//  States: IDLE -> ISSUE -> DRAIN -> IDLE. Abort from ISSUE/DRAIN goes to FLUSH -> IDLE.
//  IDLE: read_launch at edge N latches start/end; at N+1 state=ISSUE, sdram_address=start, busy=1.
//  ISSUE: sdram_read=1 only while outstanding+fifo_count < FIFO_DEPTH (credit).
//   Once asserted, sdram_read and sdram_address hold until accepted (read & !waitrequest).
//   On acceptance: if address==end, drop sdram_read next cycle and go to DRAIN; else address+1.
//   Address increments mod 2^ADDR_W, so start>end wraps through max address.
//  Outstanding counter: +1 on acceptance, -1 on readdatavalid, both in the same cycle = no change.
//   readdatavalid with outstanding==0 is ignored.
//  Returned lines enter the FIFO in order with a last flag, set when the return count
//   reaches end-start+1. The FIFO never overflows, guaranteed by credit.
//  Serializer: holds one line; word k = line[OUT_W*k +: OUT_W], k=0 first.
//   out_data/out_valid/out_last stay stable while out_valid & !out_ready.
//   A new line loads in the same cycle the final word is taken, so there is no bubble.
//   out_last=1 only on word DATA_W/OUT_W-1 of the flagged line.
//  DRAIN: go to IDLE when outstanding==0, FIFO empty and serializer empty (final out_last word
//   accepted); busy drops the same edge.
//  read_abort while busy: stop issuing new reads. If sdram_read is asserted and stalled, hold it
//   until accepted, then drop it. Next cycle out_valid=0, and FIFO and serializer are cleared.
//   Go to FLUSH, which discards every return until outstanding==0, then IDLE. No out_last is emitted.
//  read_launch while busy is ignored. Launch and abort in the same IDLE cycle: launch wins, abort ignored.
//  Latency: launch edge N -> sdram_read at N+1; readdatavalid at edge M -> out_valid at M+1 if the
//   serializer is empty.
//  rst_sdram_n low mid-transfer: immediate return to reset values. In-flight returns after
//   reset release are ignored (outstanding==0).
// TESTING
//  start=0x10,end=0x13, waitreq=0, rd latency 3, ready=1 -> 4 reads 0x10..0x13, 32 words, out_last on word 32 only.
//  Same, out_ready=0 -> exactly FIFO_DEPTH=8 reads issued, sdram_read low until words drain; no data lost.
//  waitrequest high 5 cycles on 2nd read -> address 0x11 and sdram_read held stable all 5 cycles.
//  start=0x7FFFFFF,end=0x0000001 -> addresses 0x7FFFFFF,0,1 issued in order, 24 words out.
//  Abort after 2 of 16 lines streamed -> out_valid low next cycle, remaining returns dropped, busy low once outstanding=0.
//  Reset asserted mid-ISSUE with 3 outstanding -> all outputs reset; post-release readdatavalid produces no out_valid.

Source files
------------

// File: rtl/sdram_readback.sv
// sdram_readback: reads an inclusive range of SDRAM lines over a pipelined Avalon-MM
// read port (burstcount 1) and streams each line out as OUT_W-bit words, lowest word first.
// The line FIFO head doubles as the serializer, so one credit covers a line from the
// moment its read is accepted until its final word has been taken.
module sdram_readback #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 256,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              sdram_clk,
  input  logic              rst_sdram_n,
  input  logic              read_launch,
  input  logic              read_abort,
  input  logic [ADDR_W-1:0] read_addr_start,
  input  logic [ADDR_W-1:0] read_addr_end,
  output logic              read_busy,
  output logic [ADDR_W-1:0] sdram_address,
  output logic [7:0]        sdram_burstcount,
  output logic              sdram_read,
  input  logic              sdram_waitrequest,
  input  logic [DATA_W-1:0] sdram_readdata,
  input  logic              sdram_readdatavalid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int WORDS  = DATA_W / OUT_W;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   end_reg, end_next;
  logic [ADDR_W-1:0]   span_reg, span_next;
  logic [ADDR_W-1:0]   ret_cnt_reg, ret_cnt_next;
  logic                read_reg, read_next;
  logic [CNT_W-1:0]    outst_reg, outst_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [WIDX_W-1:0]   widx_reg, widx_next;

  // Line storage; the entry at rd_ptr_reg is the line currently being serialized.
  logic [DATA_W-1:0]   fifo_data_mem [FIFO_DEPTH];
  logic                fifo_last_mem [FIFO_DEPTH];

  logic                accept;
  logic                rdv_ok;
  logic                push;
  logic                take;
  logic                pop;
  logic                credit;
  logic                clear_fifo;
  logic                head_valid;
  logic [DATA_W-1:0]   head_line;
  logic [OUT_W-1:0]    head_words [WORDS];

  assign accept     = read_reg && !sdram_waitrequest;
  // Returns with nothing outstanding (e.g. in flight across a reset) are dropped.
  assign rdv_ok     = sdram_readdatavalid && (outst_reg != '0);
  assign push       = rdv_ok && ((state_reg == S_ISSUE) || (state_reg == S_DRAIN));
  assign head_valid = (count_reg != '0);
  assign take       = head_valid && out_ready;
  assign pop        = take && (widx_reg == WIDX_LAST);
  assign head_line  = fifo_data_mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_words
      assign head_words[gi] = head_line[gi*OUT_W +: OUT_W];
    end
  endgenerate

  assign sdram_address    = addr_reg;
  assign sdram_read       = read_reg;
  assign sdram_burstcount = 8'd1;
  assign read_busy        = (state_reg != S_IDLE);
  assign out_valid        = head_valid;
  assign out_data         = head_valid ? head_words[widx_reg] : '0;
  assign out_last         = head_valid && fifo_last_mem[rd_ptr_reg] && (widx_reg == WIDX_LAST);

  // Line storage write; the last flag marks the final line of the requested range.
  always_ff @(posedge sdram_clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_reg] <= sdram_readdata;
      fifo_last_mem[wr_ptr_reg] <= (ret_cnt_reg == span_reg);
    end
  end

  // State and counter registers.
  always_ff @(posedge sdram_clk or negedge rst_sdram_n) begin
    if (!rst_sdram_n) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      end_reg     <= '0;
      span_reg    <= '0;
      ret_cnt_reg <= '0;
      read_reg    <= 1'b0;
      outst_reg   <= '0;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      widx_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      end_reg     <= end_next;
      span_reg    <= span_next;
      ret_cnt_reg <= ret_cnt_next;
      read_reg    <= read_next;
      outst_reg   <= outst_next;
      count_reg   <= count_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      widx_reg    <= widx_next;
    end
  end

  // Next-state logic: read issue with credit, FIFO/serializer bookkeeping, abort flush.
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    end_next     = end_reg;
    span_next    = span_reg;
    read_next    = read_reg;
    ret_cnt_next = ret_cnt_reg + ADDR_W'(push);
    outst_next   = outst_reg + CNT_W'(accept) - CNT_W'(rdv_ok);
    count_next   = count_reg + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_next  = wr_ptr_reg + PTR_W'(push);
    rd_ptr_next  = rd_ptr_reg + PTR_W'(pop);
    widx_next    = widx_reg;
    clear_fifo   = 1'b0;
    if (take) begin
      widx_next = (widx_reg == WIDX_LAST) ? '0 : widx_reg + 1'b1;
    end
    // Credit is judged on next-cycle occupancy so a line is never requested without a slot.
    credit = ({1'b0, outst_next} + {1'b0, count_next}) < SUM_W'(FIFO_DEPTH);

    case (state_reg)
      S_IDLE: begin
        if (read_launch) begin
          addr_next    = read_addr_start;
          end_next     = read_addr_end;
          span_next    = read_addr_end - read_addr_start;
          ret_cnt_next = '0;
          read_next    = 1'b1;
          state_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (read_abort) begin
          // A stalled request must still complete; everything buffered is thrown away.
          read_next  = read_reg && !accept;
          clear_fifo = 1'b1;
          state_next = S_FLUSH;
        end else if (accept) begin
          if (addr_reg == end_reg) begin
            read_next  = 1'b0;
            state_next = S_DRAIN;
          end else begin
            addr_next = addr_reg + 1'b1;
            read_next = credit;
          end
        end else if (!read_reg) begin
          read_next = credit;
        end
      end
      S_DRAIN: begin
        if (read_abort) begin
          read_next  = 1'b0;
          clear_fifo = 1'b1;
          state_next = S_FLUSH;
        end else if ((outst_next == '0) && (count_next == '0)) begin
          state_next = S_IDLE;
        end
      end
      S_FLUSH: begin
        read_next = read_reg && !accept;
        if ((outst_next == '0) && !read_next) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        read_next  = 1'b0;
      end
    endcase

    if (clear_fifo) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      widx_next   = '0;
    end
  end

endmodule

// File: tb/tb_sdram_readback.sv
// tb_sdram_readback: directed tests with a pipelined SDRAM slave model, an expected-word
// scoreboard popped by an independent output monitor, and an expected-address queue
// checked on each accepted read.
module tb_sdram_readback;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 256;
  localparam int OUT_W  = 32;
  localparam int WORDS  = 8;
  localparam int LAT    = 3;

  logic              sdram_clk = 1'b0;
  logic              rst_sdram_n = 1'b0;
  logic              read_launch = 1'b0;
  logic              read_abort = 1'b0;
  logic [ADDR_W-1:0] read_addr_start = '0;
  logic [ADDR_W-1:0] read_addr_end = '0;
  logic              read_busy;
  logic [ADDR_W-1:0] sdram_address;
  logic [7:0]        sdram_burstcount;
  logic              sdram_read;
  logic              sdram_waitrequest = 1'b0;
  logic [DATA_W-1:0] sdram_readdata = '0;
  logic              sdram_readdatavalid = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;

  sdram_readback #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .FIFO_DEPTH(8)
  ) dut (
    .sdram_clk(sdram_clk),
    .rst_sdram_n(rst_sdram_n),
    .read_launch(read_launch),
    .read_abort(read_abort),
    .read_addr_start(read_addr_start),
    .read_addr_end(read_addr_end),
    .read_busy(read_busy),
    .sdram_address(sdram_address),
    .sdram_burstcount(sdram_burstcount),
    .sdram_read(sdram_read),
    .sdram_waitrequest(sdram_waitrequest),
    .sdram_readdata(sdram_readdata),
    .sdram_readdatavalid(sdram_readdatavalid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 sdram_clk = ~sdram_clk;

  typedef struct { logic [OUT_W-1:0] data; logic last; } exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; int due; } pend_t;

  exp_t              exp_q[$];
  pend_t             pend_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int total = 0;
  int bad = 0;
  int rd_total = 0;
  int stall_cycles = 0;
  int mon_words = 0;
  int stall_gen = 0;
  logic [ADDR_W-1:0] stall_addr = '0;

  function automatic logic [OUT_W-1:0] word_of(logic [ADDR_W-1:0] a, int k);
    logic [3:0] kk;
    kk = 4'(k);
    return {1'b0, a, kk};
  endfunction

  function automatic logic [DATA_W-1:0] line_of(logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] l;
    l = '0;
    for (int k = 0; k < WORDS; k++) l[k*OUT_W +: OUT_W] = word_of(a, k);
    return l;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sdram_clk);
    #1;
  endtask

  // Avalon slave model: fixed read latency, optional 5-cycle stall on one address.
  initial begin
    int    stall_left;
    int    stall_seen;
    bit    stall_on;
    int    cyc;
    pend_t p;
    logic [ADDR_W-1:0] ea;
    stall_left = 0;
    stall_seen = 0;
    stall_on = 0;
    cyc = 0;
    forever begin
      @(negedge sdram_clk);
      cyc++;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        sdram_readdatavalid = 1'b1;
        sdram_readdata = line_of(p.addr);
      end else begin
        sdram_readdatavalid = 1'b0;
        sdram_readdata = '0;
      end
      if (stall_gen != stall_seen) begin
        stall_seen = stall_gen;
        stall_left = 5;
        stall_on = 0;
      end
      if (stall_left > 0 && (stall_on || (sdram_read && sdram_address == stall_addr))) begin
        if (stall_on) begin
          check("stall_read_held", 64'(sdram_read), 64'd1);
          check("stall_addr_held", 64'(sdram_address), 64'(stall_addr));
        end
        stall_on = 1;
        sdram_waitrequest = 1'b1;
        stall_left--;
        stall_cycles++;
      end else begin
        stall_on = 0;
        sdram_waitrequest = 1'b0;
      end
      if (rst_sdram_n && sdram_read && !sdram_waitrequest) begin
        rd_total++;
        pend_q.push_back('{addr: sdram_address, due: cyc + LAT});
        total++;
        if (exp_addr_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: got addr 0x%0h required none", sdram_address);
        end else begin
          ea = exp_addr_q.pop_front();
          total--;
          check("read_addr", 64'(sdram_address), 64'(ea));
        end
      end
    end
  end

  // Output monitor: every accepted word is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge sdram_clk);
      #2;
      if (rst_sdram_n && out_valid && out_ready) begin
        mon_words++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got data 0x%0h last %0d required none", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          $display("word data=0x%08h last=%0d", out_data, out_last);
          check("word_data", 64'(out_data), 64'(e.data));
          check("word_last", 64'(out_last), 64'(e.last));
        end
      end
    end
  end

  task automatic launch(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                        input int n_exp_lines, input int n_addr, input bit with_last);
    logic [ADDR_W-1:0] a;
    read_addr_start = s;
    read_addr_end = e;
    for (int i = 0; i < n_addr; i++) begin
      a = s + ADDR_W'(i);
      exp_addr_q.push_back(a);
    end
    for (int i = 0; i < n_exp_lines; i++) begin
      a = s + ADDR_W'(i);
      for (int k = 0; k < WORDS; k++)
        exp_q.push_back('{data: word_of(a, k),
                          last: with_last && (i == n_exp_lines - 1) && (k == WORDS - 1)});
    end
    read_launch = 1'b1;
    tick();
    read_launch = 1'b0;
    check("launch_read", 64'(sdram_read), 64'd1);
    check("launch_busy", 64'(read_busy), 64'd1);
    check("launch_addr", 64'(sdram_address), 64'(s));
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    while (read_busy && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, 64'(read_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int wbase;
    int sent;
    int n;
    int seen;

    // Reset values
    repeat (3) tick();
    check("rst_busy", 64'(read_busy), 64'd0);
    check("rst_read", 64'(sdram_read), 64'd0);
    check("rst_addr", 64'(sdram_address), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("burstcount", 64'(sdram_burstcount), 64'd1);
    rst_sdram_n = 1'b1;
    tick();

    // 1: basic 4-line transfer, ready held high
    out_ready = 1'b1;
    base = rd_total;
    launch(27'h10, 27'h13, 4, 4, 1'b1);
    wait_idle("t1_idle", 200);
    check("t1_reads", 64'(rd_total - base), 64'd4);
    check("t1_left", 64'(exp_q.size()), 64'd0);

    // 2: backpressure, credit limits outstanding+buffered lines to 8
    out_ready = 1'b0;
    base = rd_total;
    launch(27'h10, 27'h1F, 16, 16, 1'b1);
    repeat (40) tick();
    check("t2_credit_reads", 64'(rd_total - base), 64'd8);
    check("t2_read_low", 64'(sdram_read), 64'd0);
    check("t2_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_idle("t2_idle", 400);
    check("t2_reads", 64'(rd_total - base), 64'd16);
    check("t2_left", 64'(exp_q.size()), 64'd0);

    // 3: waitrequest held 5 cycles on the second read
    stall_addr = 27'h11;
    base = stall_cycles;
    stall_gen++;
    launch(27'h10, 27'h13, 4, 4, 1'b1);
    wait_idle("t3_idle", 200);
    check("t3_stall_cycles", 64'(stall_cycles - base), 64'd5);
    check("t3_left", 64'(exp_q.size()), 64'd0);

    // 4: address wrap through the maximum line address
    base = rd_total;
    wbase = mon_words;
    launch(27'h7FFFFFF, 27'h0000001, 3, 3, 1'b1);
    wait_idle("t4_idle", 200);
    check("t4_reads", 64'(rd_total - base), 64'd3);
    check("t4_words", 64'(mon_words - wbase), 64'd24);
    check("t4_left", 64'(exp_q.size()), 64'd0);

    // 5: abort after two of sixteen lines have been streamed
    out_ready = 1'b0;
    launch(27'h40, 27'h4F, 2, 16, 1'b0);
    sent = 0;
    n = 0;
    while (sent < 16 && n < 400) begin
      if (out_valid) begin
        out_ready = 1'b1;
        sent++;
      end else begin
        out_ready = 1'b0;
      end
      tick();
      n++;
    end
    check("t5_streamed", 64'(sent), 64'd16);
    out_ready = 1'b0;
    read_abort = 1'b1;
    tick();
    read_abort = 1'b0;
    check("t5_valid_dropped", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    seen = 0;
    n = 0;
    while (read_busy && n < 100) begin
      if (out_valid) seen++;
      tick();
      n++;
    end
    check("t5_idle", 64'(read_busy), 64'd0);
    check("t5_no_output", 64'(seen), 64'd0);
    check("t5_no_pending", 64'(pend_q.size()), 64'd0);
    check("t5_left", 64'(exp_q.size()), 64'd0);
    exp_addr_q.delete();

    // 6: reset mid-ISSUE with reads outstanding
    out_ready = 1'b0;
    base = rd_total;
    launch(27'h20, 27'h2F, 0, 16, 1'b0);
    n = 0;
    while ((rd_total - base) < 3 && n < 50) begin
      tick();
      n++;
    end
    tick();
    rst_sdram_n = 1'b0;
    #1;
    check("t6_rst_read", 64'(sdram_read), 64'd0);
    check("t6_rst_busy", 64'(read_busy), 64'd0);
    check("t6_rst_addr", 64'(sdram_address), 64'd0);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    exp_addr_q.delete();
    tick();
    rst_sdram_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid || sdram_read || read_busy) seen++;
    end
    check("t6_post_reset_quiet", 64'(seen), 64'd0);
    check("t6_pending_drained", 64'(pend_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
